// File: rtl/spi_flash_boot_loader_if.sv
// Flash pin and IMEM write-port bundle between the boot loader and the FPGA top.
// The boot loader drives the flash pins and the IMEM port through the master modport.
interface spi_flash_boot_loader_if #(
    parameter int unsigned IMEM_DEPTH = 512
);
    localparam int unsigned AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

    logic          o_flash_sclk;
    logic          o_flash_cs_n;
    logic          o_flash_mosi;
    logic          i_flash_miso;
    logic          imem_we_o;
    logic [AW-1:0] imem_addr_o;
    logic [31:0]   imem_wdata_o;

    modport master (
        output o_flash_sclk, o_flash_cs_n, o_flash_mosi,
        output imem_we_o, imem_addr_o, imem_wdata_o,
        input  i_flash_miso
    );

    modport slave (
        input  o_flash_sclk, o_flash_cs_n, o_flash_mosi,
        input  imem_we_o, imem_addr_o, imem_wdata_o,
        output i_flash_miso
    );
endinterface

// File: rtl/spi_flash_boot_loader.sv
// Copies the program image from SPI flash into IMEM with a single READ (0x03)
// transaction, then releases the core reset.
module spi_flash_boot_loader #(
    parameter logic [23:0] FLASH_BASE_ADDR = 24'h300000,
    parameter int unsigned IMEM_DEPTH      = 512,
    parameter int unsigned SCLK_DIV        = 2
) (
    input  logic                           clk_i,
    input  logic                           reset_n,
    input  logic                           skip_i,
    spi_flash_boot_loader_if.master        bus,
    output logic                           core_reset_n_o,
    output logic                           boot_done_o,
    output logic                           boot_err_o
);
    localparam int unsigned AW      = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    localparam int unsigned CW      = $clog2(SCLK_DIV + 1);
    localparam logic [CW-1:0] DivLast = CW'(SCLK_DIV - 1);
    localparam logic [AW-1:0] LastIdx = AW'(IMEM_DEPTH - 1);
    localparam logic [7:0]    CmdRead = 8'h03;

    typedef enum logic [2:0] {
        StIdle, StCsSetup, StCmd, StAddr, StData, StWrite, StCsHold, StDone
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] div_q;
    logic [4:0]    bit_q;
    logic          sclk_q, mosi_q;
    logic          cs_n_q, cs_n_d;
    logic          we_q, we_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [31:0]   tx_q, rx_q, wdata_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   word;
    logic          shifting, tick, rise, fall, erased;

    assign shifting = state_q inside {StCmd, StAddr, StData};
    assign tick     = (div_q == DivLast);
    assign rise     = shifting && tick && !sclk_q;
    assign fall     = shifting && tick && sclk_q;
    // Bytes arrive in flash order; the first byte is the least significant.
    assign word     = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
    assign erased   = (wdata_q == 32'hFFFF_FFFF);

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    state_d = skip_i ? StDone : StCsSetup;
            StCsSetup: if (tick) state_d = StCmd;
            StCmd:     if (fall && bit_q == 5'd7) state_d = StAddr;
            StAddr:    if (fall && bit_q == 5'd31) state_d = StData;
            StData:    if (fall && bit_q == 5'd31) state_d = StWrite;
            StWrite:   state_d = (erased || idx_q == LastIdx) ? StCsHold : StData;
            StCsHold:  if (tick) state_d = StDone;
            StDone:    state_d = StDone;
            default:   state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs, decoded from the upcoming state.
    always_comb begin
        cs_n_d = !(state_d inside {StCsSetup, StCmd, StAddr, StData, StWrite});
        we_d   = (state_d == StWrite) && (word != 32'hFFFF_FFFF);
        done_d = (state_d == StDone);
        err_d  = err_q || (state_q == StWrite && erased && idx_q == '0);
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            div_q   <= '0;
            bit_q   <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            tx_q    <= '0;
            rx_q    <= '0;
            wdata_q <= '0;
            idx_q   <= '0;
        end else begin
            cs_n_q <= cs_n_d;
            we_q   <= we_d;
            done_q <= done_d;
            err_q  <= err_d;

            if (state_d != state_q || tick) begin
                div_q <= '0;
            end else begin
                div_q <= div_q + CW'(1);
            end

            if (!shifting) begin
                sclk_q <= 1'b0;
            end else if (tick) begin
                sclk_q <= ~sclk_q;
            end

            // First MOSI bit is presented while SCLK is still low, before CMD starts.
            if (state_q == StCsSetup && tick) begin
                tx_q   <= {CmdRead, FLASH_BASE_ADDR};
                mosi_q <= CmdRead[7];
            end else if (fall && state_q != StData) begin
                tx_q   <= tx_q << 1;
                mosi_q <= tx_q[30];
            end

            if (fall) begin
                bit_q <= bit_q + 5'd1;
            end

            if (rise && state_q == StData) begin
                rx_q <= {rx_q[30:0], bus.i_flash_miso};
            end

            if (state_d == StWrite) begin
                wdata_q <= word;
            end

            if (state_q == StWrite && state_d == StData) begin
                idx_q <= idx_q + AW'(1);
            end
        end
    end

    assign bus.o_flash_sclk = sclk_q;
    assign bus.o_flash_cs_n = cs_n_q;
    assign bus.o_flash_mosi = mosi_q;
    assign bus.imem_we_o    = we_q;
    assign bus.imem_addr_o  = idx_q;
    assign bus.imem_wdata_o = wdata_q;
    assign core_reset_n_o   = done_q;
    assign boot_done_o      = done_q;
    assign boot_err_o       = err_q;
endmodule

// File: tb/tb_spi_flash_boot_loader.sv
// Boot loader bench: behavioural SPI flash, IMEM write scoreboard and SPI protocol monitor,
// with directed and $urandom flash images.
module tb_spi_flash_boot_loader;
    localparam int unsigned Depth   = 8;
    localparam int unsigned Div     = 2;
    localparam logic [31:0] CmdAddr = 32'h0330_0000;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic skip = 1'b0;
    logic core_reset_n, boot_done, boot_err;

    spi_flash_boot_loader_if #(.IMEM_DEPTH(Depth)) bus ();

    spi_flash_boot_loader #(
        .FLASH_BASE_ADDR(24'h300000),
        .IMEM_DEPTH     (Depth),
        .SCLK_DIV       (Div)
    ) dut (
        .clk_i         (clk),
        .reset_n       (reset_n),
        .skip_i        (skip),
        .bus           (bus),
        .core_reset_n_o(core_reset_n),
        .boot_done_o   (boot_done),
        .boot_err_o    (boot_err)
    );

    always #5 clk = ~clk;

    wr_t        exp_q[$];
    logic [7:0] flash [Depth*4];
    int         n_checks = 0;
    int         n_err = 0;
    int         writes_total = 0;
    int         cs_low_total = 0;
    int         wr_base, cs_base, exp_lat, exp_n;
    bit         exp_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural flash: captures command+address, then streams bytes MSB first on SCLK fall.
    int         rise_cnt = 0;
    logic [31:0] cmd_sh = '0;
    logic        sclk_prev = 1'b0;
    initial bus.i_flash_miso = 1'b0;
    always @(bus.o_flash_sclk or bus.o_flash_cs_n) begin
        int bp;
        if (bus.o_flash_cs_n !== 1'b0) begin
            rise_cnt = 0;
            bus.i_flash_miso = 1'b0;
        end else if (bus.o_flash_sclk === 1'b1 && sclk_prev === 1'b0) begin
            if (rise_cnt < 32) cmd_sh = {cmd_sh[30:0], bus.o_flash_mosi};
            rise_cnt++;
            if (rise_cnt == 32) check("cmd_addr_on_mosi", cmd_sh, CmdAddr);
        end else if (bus.o_flash_sclk === 1'b0 && sclk_prev === 1'b1 && rise_cnt >= 32) begin
            bp = rise_cnt - 32;
            bus.i_flash_miso = (bp / 8 < int'(Depth * 4)) ? flash[bp / 8][7 - bp % 8] : 1'b1;
        end
        sclk_prev = bus.o_flash_sclk;
    end

    // Write scoreboard and SPI protocol monitor, sampled mid-cycle.
    logic prev_sclk = 1'b0, prev_mosi = 1'b0, prev_cs = 1'b1, prev_we = 1'b0;
    int   ph_len = 0;
    bit   have_edge = 0, we_in_phase = 0;
    always @(negedge clk) begin
        wr_t e;
        if (reset_n !== 1'b1) begin
            have_edge = 0;
        end else begin
            if (bus.o_flash_cs_n === 1'b0) cs_low_total++;
            if (bus.imem_we_o === 1'b1) begin
                writes_total++;
                check("we_single_cycle", prev_we, 0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_write: addr=%0d data=%h, expected no write",
                             bus.imem_addr_o, bus.imem_wdata_o);
                end else begin
                    e = exp_q.pop_front();
                    check("imem_addr", bus.imem_addr_o, e.addr);
                    check("imem_wdata", bus.imem_wdata_o, e.data);
                end
            end
            if (bus.o_flash_cs_n !== prev_cs) begin
                check("sclk_low_at_cs_edge", {prev_sclk, bus.o_flash_sclk}, 0);
                have_edge = 0;
            end
            if (prev_sclk && bus.o_flash_sclk) check("mosi_stable_sclk_high", bus.o_flash_mosi,
                                                      prev_mosi);
            if (bus.o_flash_cs_n === 1'b0) begin
                if (bus.o_flash_sclk !== prev_sclk) begin
                    if (have_edge) begin
                        if (prev_sclk) check("sclk_high_len", ph_len, Div);
                        else check("sclk_low_len", ph_len, we_in_phase ? Div + 1 : Div);
                    end
                    have_edge   = 1;
                    ph_len      = 1;
                    we_in_phase = bus.imem_we_o;
                end else begin
                    ph_len++;
                    we_in_phase = we_in_phase | bus.imem_we_o;
                end
            end
        end
        prev_sclk = bus.o_flash_sclk;
        prev_mosi = bus.o_flash_mosi;
        prev_cs   = bus.o_flash_cs_n;
        prev_we   = bus.imem_we_o;
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_cs_n"}, bus.o_flash_cs_n, 1);
        check({tag, "_sclk"}, bus.o_flash_sclk, 0);
        check({tag, "_mosi"}, bus.o_flash_mosi, 0);
        check({tag, "_we"}, bus.imem_we_o, 0);
        check({tag, "_addr"}, bus.imem_addr_o, 0);
        check({tag, "_wdata"}, bus.imem_wdata_o, 0);
        check({tag, "_core_reset_n"}, core_reset_n, 0);
        check({tag, "_boot_done"}, boot_done, 0);
        check({tag, "_boot_err"}, boot_err, 0);
    endtask

    // Reference model: words load in order until an erased word or a full IMEM.
    task automatic start_boot(input bit skip_v);
        int n_read;
        reset_n = 1'b0;
        skip    = skip_v;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        exp_q.delete();
        exp_err = 0;
        exp_n   = 0;
        n_read  = 0;
        if (!skip_v) begin
            for (int k = 0; k < int'(Depth); k++) begin
                logic [31:0] w;
                w = {flash[4*k+3], flash[4*k+2], flash[4*k+1], flash[4*k]};
                n_read++;
                if (w == 32'hFFFF_FFFF) begin
                    exp_err = (k == 0);
                    break;
                end
                exp_q.push_back('{addr: k, data: w});
                exp_n++;
            end
            exp_lat = 1 + Div + 64 * Div + n_read * (64 * Div + 1) + Div;
        end else begin
            exp_lat = 1;
        end
        wr_base = writes_total;
        cs_base = cs_low_total;
        @(negedge clk) reset_n = 1'b1;
    endtask

    task automatic finish_boot(input bit skip_v);
        int edges = 0;
        bit seen = 0;
        while (edges < 4000 && !seen) begin
            @(posedge clk);
            edges++;
            #1 seen = core_reset_n;
        end
        if (!seen) begin
            n_checks++;
            n_err++;
            $display("FAIL boot_timeout: core_reset_n still 0 after %0d cycles, expected %0d",
                     edges, exp_lat);
        end else begin
            check("release_cycle", edges, exp_lat);
        end
        check("boot_done", boot_done, 1);
        check("boot_err", boot_err, exp_err);
        check("cs_n_after_boot", bus.o_flash_cs_n, 1);
        check("pending_writes", exp_q.size(), 0);
        check("write_count", writes_total - wr_base, exp_n);
        check("cs_went_low", (cs_low_total - cs_base) != 0, !skip_v);
    endtask

    task automatic run_boot(input bit skip_v);
        start_boot(skip_v);
        finish_boot(skip_v);
    endtask

    task automatic fill_incr();
        for (int i = 0; i < int'(Depth * 4); i++) flash[i] = 8'(i);
    endtask

    initial begin
        int waited;
        // Full image of incrementing bytes.
        fill_incr();
        run_boot(0);
        // Erased word 3.
        for (int j = 12; j < 16; j++) flash[j] = 8'hFF;
        run_boot(0);
        // Blank flash.
        for (int i = 0; i < int'(Depth * 4); i++) flash[i] = 8'hFF;
        run_boot(0);
        // Bypass.
        fill_incr();
        run_boot(1);
        // Abort during DATA of word 4, then a clean reload.
        start_boot(0);
        waited = 0;
        while (writes_total - wr_base < 4 && waited < 2000) begin
            @(posedge clk);
            waited++;
        end
        if (waited >= 2000) begin
            n_checks++;
            n_err++;
            $display("FAIL abort_wait: got %0d writes, expected 4", writes_total - wr_base);
        end
        repeat (20) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("abort_cs_n", bus.o_flash_cs_n, 1);
        check("abort_core_reset_n", core_reset_n, 0);
        check("abort_sclk", bus.o_flash_sclk, 0);
        check("abort_addr", bus.imem_addr_o, 0);
        run_boot(0);
        // Random images, random erased word, occasional bypass.
        for (int r = 0; r < 5; r++) begin
            int ew;
            bit sk;
            for (int i = 0; i < int'(Depth * 4); i++) flash[i] = 8'($urandom);
            ew = $urandom_range(0, Depth + 2);
            if (ew < int'(Depth)) for (int j = 0; j < 4; j++) flash[4*ew+j] = 8'hFF;
            sk = ($urandom_range(0, 4) == 0);
            run_boot(sk);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
        $fatal(1);
    end
endmodule
